multicycle_decoder: RTL and testbench

//  Multi-cycle successor to the single-cycle RISC-V decoder. Latches one instruction per handshake
//  and sequences ALU, load (address/memory/writeback) and store (address/memory) through an FSM.

---
 rtl/multicycle_decoder.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// Multi-cycle RISC-V decoder: latches one instruction per fetch handshake and steps it through
// execute, memory and writeback states, driving datapath controls as a Moore machine.
module multicycle_decoder #(
  parameter int ALUOP_W      = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter bit CHECK_FUNCT7 = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               mem_ack,
  input  logic               trap_clr,
  output logic [ALUOP_W-1:0] AluOp,
  output logic               regw,
  output logic               imm,
  output logic               incr,
  output logic               memr,
  output logic               memw,
  output logic [2:0]         mem_size,
  output logic               wbsel,
  output logic               illegal
);

  localparam logic [6:0] OP_RALU   = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_ILOAD  = 7'b0000011;
  localparam logic [6:0] OP_SSTORE = 7'b0100011;

  localparam int CNT_W = (MEM_TIMEOUT <= 1) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_DECODE = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_WB     = 3'd3,
    S_TRAP   = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ir_load;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_ialu, is_load, is_store, bad;
  logic [3:0] alu_op4;
  logic       unused_ir_bits;

  assign opcode         = ir[6:0];
  assign funct3         = ir[14:12];
  assign funct7         = ir[31:25];
  assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

  // Flags encodings outside the supported RV32I ALU/load/store subset.
  function automatic logic enc_illegal(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
    logic f7_ok, shift;
    f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
    shift = (f3 == 3'b001) || (f3 == 3'b101);
    case (op)
      OP_RALU:   enc_illegal = CHECK_FUNCT7 && !f7_ok;
      OP_IALU:   enc_illegal = CHECK_FUNCT7 && shift && !f7_ok;
      OP_ILOAD:  enc_illegal = !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                                 (f3 == 3'b100) || (f3 == 3'b101));
      OP_SSTORE: enc_illegal = (f3 > 3'b010);
      default:   enc_illegal = 1'b1;
    endcase
  endfunction

  // Only the shift-immediate form of IALU carries the arithmetic/logical bit in funct7.
  function automatic logic [3:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
    case (op)
      OP_RALU: alu_decode = {f3, f7[5]};
      OP_IALU: alu_decode = (f3 == 3'b101) ? {f3, f7[5]} : {f3, 1'b0};
      default: alu_decode = 4'b0000;
    endcase
  endfunction

  assign is_ialu  = (opcode == OP_IALU);
  assign is_load  = (opcode == OP_ILOAD);
  assign is_store = (opcode == OP_SSTORE);
  assign bad      = enc_illegal(opcode, funct3, funct7);
  assign alu_op4  = alu_decode(opcode, funct3, funct7);

  // State, instruction register and memory-wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_DECODE;
      ir    <= 32'h0000_0000;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (ir_load) begin
        ir <= instr;
      end else begin
        ir <= ir;
      end
    end
  end

  // Next-state logic and Moore outputs; incr on a store also follows the acknowledge.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ir_load     = 1'b0;
    instr_ready = 1'b0;
    AluOp       = '0;
    regw        = 1'b0;
    imm         = 1'b0;
    incr        = 1'b0;
    memr        = 1'b0;
    memw        = 1'b0;
    mem_size    = 3'b000;
    wbsel       = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_DECODE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_load  = 1'b1;
          state_nx = S_EXEC;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_EXEC: begin
        if (bad) begin
          state_nx = S_TRAP;
        end else if (is_load || is_store) begin
          imm      = 1'b1;
          cnt_nx   = '0;
          state_nx = S_MEM;
        end else begin
          AluOp[3:0] = alu_op4;
          regw       = 1'b1;
          incr       = 1'b1;
          imm        = is_ialu;
          state_nx   = S_DECODE;
        end
      end
      S_MEM: begin
        memr     = is_load;
        memw     = is_store;
        imm      = 1'b1;
        mem_size = funct3;
        if (mem_ack) begin
          if (is_load) begin
            state_nx = S_WB;
          end else begin
            incr     = 1'b1;
            state_nx = S_DECODE;
          end
        end else if (MEM_TIMEOUT != 0) begin
          if (cnt == CNT_LAST) begin
            state_nx = S_TRAP;
          end else begin
            cnt_nx   = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state_nx = S_MEM;
          end
        end else begin
          state_nx = S_MEM;
        end
      end
      S_WB: begin
        regw     = 1'b1;
        wbsel    = 1'b1;
        incr     = 1'b1;
        mem_size = funct3;
        state_nx = S_DECODE;
      end
      S_TRAP: begin
        illegal = 1'b1;
        if (trap_clr) begin
          state_nx = S_DECODE;
        end else begin
          state_nx = S_TRAP;
        end
      end
      default: begin
        state_nx = S_DECODE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Self-checking bench for multicycle_decoder: table of ALU/illegal encodings through a scoreboard
// queue, plus hand-written load, store, timeout, trap-clear and mid-access reset sequences.
module tb_multicycle_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        mem_ack;
  logic        trap_clr;
  logic [3:0]  alu_op;
  logic        regw, imm, incr, memr, memw, wbsel, illegal;
  logic [2:0]  mem_size;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  aluop;
    logic        imm;
    logic        bad;
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];

  multicycle_decoder #(
    .ALUOP_W(4),
    .MEM_TIMEOUT(4),
    .CHECK_FUNCT7(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .mem_ack(mem_ack),
    .trap_clr(trap_clr),
    .AluOp(alu_op),
    .regw(regw),
    .imm(imm),
    .incr(incr),
    .memr(memr),
    .memw(memw),
    .mem_size(mem_size),
    .wbsel(wbsel),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Presents one instruction in S_DECODE; returns at the start of the execute cycle.
  task automatic accept(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    smp;
    chk("accept_ready", {31'b0, instr_ready}, 32'd1);
    nxt;
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t exp;
    logic got, saw_incr;
    accept(v.instr);
    sb.push_back(v);
    got      = 1'b0;
    saw_incr = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      smp;
      if (incr) saw_incr = 1'b1;
      if (regw || illegal) got = 1'b1;
      else nxt;
    end
    chk("vec_result_seen", {31'b0, got}, 32'd1);
    exp = sb.pop_front();
    chk("vec_aluop",   {28'b0, alu_op},  exp.bad ? 32'd0 : {28'b0, exp.aluop});
    chk("vec_imm",     {31'b0, imm},     exp.bad ? 32'd0 : {31'b0, exp.imm});
    chk("vec_illegal", {31'b0, illegal}, {31'b0, exp.bad});
    chk("vec_regw",    {31'b0, regw},    {31'b0, !exp.bad});
    chk("vec_incr",    {31'b0, incr},    {31'b0, !exp.bad});
    chk("vec_ready",   {31'b0, instr_ready}, 32'd0);
    if (exp.bad) chk("vec_no_incr_trap", {31'b0, saw_incr}, 32'd0);
    nxt;
    if (exp.bad) begin
      trap_clr = 1'b1;
      smp;
      chk("vec_trap_hold", {31'b0, illegal}, 32'd1);
      nxt;
      trap_clr = 1'b0;
    end
    smp;
    chk("vec_back_ready", {31'b0, instr_ready}, 32'd1);
    chk("vec_back_regw",  {31'b0, regw}, 32'd0);
    nxt;
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 4'b0000, 1'b0, 1'b0}; // add
    vecs[1]  = '{32'h402081B3, 4'b0001, 1'b0, 1'b0}; // sub
    vecs[2]  = '{32'h0020E1B3, 4'b1100, 1'b0, 1'b0}; // or
    vecs[3]  = '{32'h4032D293, 4'b1011, 1'b1, 1'b0}; // srai
    vecs[4]  = '{32'h0032D293, 4'b1010, 1'b1, 1'b0}; // srli
    vecs[5]  = '{32'h00508093, 4'b0000, 1'b1, 1'b0}; // addi
    vecs[6]  = '{32'hFFF0F093, 4'b1110, 1'b1, 1'b0}; // andi, all-ones immediate
    vecs[7]  = '{32'h00109093, 4'b0010, 1'b1, 1'b0}; // slli
    vecs[8]  = '{32'h0000007F, 4'b0000, 1'b0, 1'b1}; // unknown opcode
    vecs[9]  = '{32'h022081B3, 4'b0000, 1'b0, 1'b1}; // mul funct7
    vecs[10] = '{32'h02109093, 4'b0000, 1'b0, 1'b1}; // slli bad funct7
    vecs[11] = '{32'h00413083, 4'b0000, 1'b0, 1'b1}; // load funct3=011
    vecs[12] = '{32'h00113223, 4'b0000, 1'b0, 1'b1}; // store funct3=011
    vecs[13] = '{32'h00114223, 4'b0000, 1'b0, 1'b1}; // store funct3=100

    reset       = 1'b1;
    instr       = 32'h0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    trap_clr    = 1'b0;
    nxt;
    nxt;
    smp;
    chk("rst_ready",   {31'b0, instr_ready}, 32'd1);
    chk("rst_outputs", {21'b0, alu_op, regw, imm, incr, memr, memw, mem_size, wbsel, illegal}, 32'd0);
    nxt;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // lw x1,4(x2) with the acknowledge on the third memory cycle.
    accept(32'h00412083);
    for (int c = 0; c < 5; c++) begin
      mem_ack = (c == 3);
      smp;
      chk("lw_memr",  {31'b0, memr},  {31'b0, (c >= 1 && c <= 3)});
      chk("lw_regw",  {31'b0, regw},  {31'b0, (c == 4)});
      chk("lw_wbsel", {31'b0, wbsel}, {31'b0, (c == 4)});
      chk("lw_incr",  {31'b0, incr},  {31'b0, (c == 4)});
      chk("lw_imm",   {31'b0, imm},   {31'b0, (c <= 3)});
      chk("lw_ready", {31'b0, instr_ready}, 32'd0);
      if (c >= 1 && c <= 3) chk("lw_size", {29'b0, mem_size}, 32'd2);
      nxt;
    end
    mem_ack = 1'b0;
    smp;
    chk("lw_done_ready", {31'b0, instr_ready}, 32'd1);
    nxt;

    // sw acknowledged in its first memory cycle.
    accept(32'h00112223);
    smp;
    chk("sw_exec_memw", {31'b0, memw}, 32'd0);
    chk("sw_exec_imm",  {31'b0, imm},  32'd1);
    chk("sw_exec_incr", {31'b0, incr}, 32'd0);
    nxt;
    mem_ack = 1'b1;
    smp;
    chk("sw_memw", {31'b0, memw}, 32'd1);
    chk("sw_memr", {31'b0, memr}, 32'd0);
    chk("sw_incr", {31'b0, incr}, 32'd1);
    chk("sw_regw", {31'b0, regw}, 32'd0);
    chk("sw_size", {29'b0, mem_size}, 32'd2);
    nxt;
    mem_ack = 1'b0;
    smp;
    chk("sw_after_memw",  {31'b0, memw}, 32'd0);
    chk("sw_after_ready", {31'b0, instr_ready}, 32'd1);
    nxt;

    // Load with no acknowledge times out after four memory cycles.
    accept(32'h00412083);
    nxt;
    for (int c = 1; c <= 4; c++) begin
      smp;
      chk("to_memr",    {31'b0, memr}, 32'd1);
      chk("to_illegal", {31'b0, illegal}, 32'd0);
      nxt;
    end
    smp;
    chk("to_trap_illegal", {31'b0, illegal}, 32'd1);
    chk("to_trap_memr",    {31'b0, memr}, 32'd0);
    chk("to_trap_ready",   {31'b0, instr_ready}, 32'd0);
    chk("to_trap_incr",    {31'b0, incr}, 32'd0);
    nxt;
    smp;
    chk("to_trap_held", {31'b0, illegal}, 32'd1);
    nxt;
    trap_clr    = 1'b1;
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    smp;
    chk("clr_ready", {31'b0, instr_ready}, 32'd0);
    nxt;
    trap_clr    = 1'b0;
    instr_valid = 1'b0;
    smp;
    chk("clr_decode_ready", {31'b0, instr_ready}, 32'd1);
    chk("clr_illegal",      {31'b0, illegal}, 32'd0);
    chk("clr_regw",         {31'b0, regw}, 32'd0);
    nxt;
    smp;
    chk("clr_not_latched", {31'b0, instr_ready}, 32'd1);
    nxt;

    // Acknowledge arriving in the timeout cycle wins over the trap.
    accept(32'h00412083);
    nxt;
    for (int c = 1; c <= 4; c++) begin
      mem_ack = (c == 4);
      smp;
      chk("ackto_memr", {31'b0, memr}, 32'd1);
      nxt;
    end
    mem_ack = 1'b0;
    smp;
    chk("ackto_illegal", {31'b0, illegal}, 32'd0);
    chk("ackto_wb",      {31'b0, wbsel}, 32'd1);
    chk("ackto_regw",    {31'b0, regw}, 32'd1);
    nxt;
    smp;
    chk("ackto_ready", {31'b0, instr_ready}, 32'd1);
    nxt;

    // Reset while a load is waiting in its memory phase.
    accept(32'h00412083);
    nxt;
    smp;
    chk("rmid_memr_before", {31'b0, memr}, 32'd1);
    reset = 1'b1;
    nxt;
    smp;
    chk("rmid_memr",  {31'b0, memr}, 32'd0);
    chk("rmid_ready", {31'b0, instr_ready}, 32'd1);
    chk("rmid_regw",  {31'b0, regw}, 32'd0);
    chk("rmid_incr",  {31'b0, incr}, 32'd0);
    nxt;
    reset   = 1'b0;
    mem_ack = 1'b1;
    smp;
    chk("rmid_after_regw", {31'b0, regw}, 32'd0);
    chk("rmid_after_incr", {31'b0, incr}, 32'd0);
    chk("rmid_after_memr", {31'b0, memr}, 32'd0);
    nxt;
    mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
